script_sequencer: RTL
=====================

# script_sequencer

Instruction sequencer for the kitchen-script engine. Fetches 16-bit script instructions from the external synchronous script ROM, decodes them and executes them in order. It runs timed waits and waituntil on kitchen feedback bits itself, resolves jumps, and hands action instructions to the UART command path over a valid/ready handshake. It replaces per-op enable juggling with a single owner of program counter and execution state.

## Interface
- ADDR_W, 8, script ROM address width; pc wraps modulo 2^ADDR_W
- clk  in  1  system (uart) clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; in IDLE or HALT begins execution at pc=0; ignored otherwise
- abort  in  1  level; forces IDLE next cycle from any state (lower priority than rst)
- ms_tick  in  1  one-clk pulse per millisecond
- feedbak_sig  in  8  kitchen state; bit2 player_ready, bit3 player_hasitem, bit4 target_ready, bit5 target_hasitem
- rom_addr  out  ADDR_W  instruction address (equals pc)
- rom_data  in  16  instruction; valid the cycle after rom_addr is presented
- cmd_valid  out  1  action instruction pending
- cmd_ready  in  1  UART path accepts action
- cmd_data  out  16  latched action instruction
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT

## Operation
- Instruction fields: [15:8] i_num, [7:5] i_sign, [4:3] func, [2:0] op.
- Signal select: i_sign 0..3 → feedbak_sig[2..5]; 4..7 → constant 0.
- States: IDLE, FETCH, DECODE, WAIT_T, WAIT_S, CMD, HALT.
- IDLE --start--> FETCH with pc=0. FETCH → DECODE (1 cycle; rom_addr=pc). DECODE latches rom_data and acts on op:
  - 000 nop, and undefined ops 100/101/110: pc+1, → FETCH.
  - 001 action: cmd_data←instruction, → CMD.
  - 010 jump: func 00 unconditional; 01 take if signal=1; 10 take if signal=0; 11 never taken. Taken: pc←i_num[ADDR_W-1:0]. Not taken: pc+1. → FETCH.
  - 011 wait: func 00 loads counter←i_num*100 (15-bit, max 25500). Counter 0 → pc+1, FETCH; else → WAIT_T. func 01 → WAIT_S. func 1x is treated as nop.
  - 111 halt: → HALT, pc held.
- WAIT_T: each ms_tick decrements counter; on the tick that reaches 0, pc+1, → FETCH.
- WAIT_S: first cycle where the selected signal=1 → pc+1, FETCH. No timeout.
- CMD: cmd_valid=1, cmd_data stable. Cycle with cmd_valid&cmd_ready → pc+1, FETCH; cmd_valid drops the next cycle.
- HALT --start--> FETCH with pc=0.
- pc increment from 2^ADDR_W-1 wraps to 0.
- abort: → IDLE, cmd_valid=0, counter cleared, pc←0. A cmd handshake in the same cycle counts as accepted but pc is not advanced.

## Timing
- Reset values: state IDLE, pc=0, rom_addr=0, cmd_valid=0, cmd_data=0, busy=0, halted=0, counter=0.
- rst has priority over abort and start. rst mid-wait or mid-CMD clears everything within the same edge.
- nop, jump and zero-length wait each take 2 cycles (FETCH+DECODE).
- wait N (N>0) completes on the (N*100)th ms_tick after DECODE, then FETCH on the next cycle. A tick coinciding with DECODE is not counted.
- WAIT_S samples feedbak_sig each cycle, unregistered. Exit occurs on the edge after the bit is seen high.
- Action: cmd_valid rises the cycle after DECODE. Minimum action cost is 3 cycles with cmd_ready held high.
- busy and halted are registered state decodes with no combinational path from inputs.

## Test plan
- Straight line: ROM {nop, action 0x2A09, halt}, cmd_ready=1 → exactly one cmd pulse with data 0x2A09; halted=1 at cycle 7 after start; pc=2.
- Timed wait: wait i_num=3 with ms_tick every 10 clks → exactly 300 ticks consumed before FETCH of pc+1. wait i_num=0 → 2 cycles.
- Waituntil: i_sign=2, feedbak_sig[4] raised 50 cycles later → exits 1 cycle after the rise. i_sign=5 → never exits until abort.
- Jumps: jumpif i_sign=1 with bit3=1 to 0x10 → next rom_addr=0x10. Same with bit3=0 → pc+1. func 11 → pc+1. Wrap at pc=0xFF → 0x00.
- Backpressure: cmd_ready low 20 cycles → cmd_valid and cmd_data stable throughout, pc unchanged, single accept.
- Reset/abort: rst during WAIT_T, and abort during CMD → all outputs at reset values next cycle. A start afterwards refetches pc=0.

Source files
------------

// File: rtl/script_sequencer.sv
// Kitchen-script instruction sequencer: it owns the program counter and the execution state,
// fetches instructions from a synchronous ROM, runs waits and jumps, and hands actions to the UART path.
module script_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ms_tick,
    input  logic [7:0]        feedbak_sig,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [15:0]       cmd_data,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT_T,
        S_WAIT_S,
        S_CMD,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ACTION = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_WAIT   = 3'b011;
    localparam logic [2:0] OP_HALT   = 3'b111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [14:0]       counter_q, counter_d;
    logic [2:0]        sign_q, sign_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [15:0]       cmd_data_q, cmd_data_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic [7:0]        i_num;
    logic [2:0]        i_sign;
    logic [1:0]        func;
    logic [2:0]        op;
    logic [ADDR_W-1:0] pc_inc;
    logic              dec_sig;
    logic              jump_take;

    // Only the four kitchen handshake bits are ever selectable.
    logic unused_fb;
    assign unused_fb = ^{feedbak_sig[7:6], feedbak_sig[1:0]};

    function automatic logic sel_sig(input logic [2:0] sign, input logic [3:0] fb);
        logic s;
        case (sign)
            3'd0:    s = fb[0];
            3'd1:    s = fb[1];
            3'd2:    s = fb[2];
            3'd3:    s = fb[3];
            default: s = 1'b0;
        endcase
        return s;
    endfunction

    assign i_num   = rom_data[15:8];
    assign i_sign  = rom_data[7:5];
    assign func    = rom_data[4:3];
    assign op      = rom_data[2:0];
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign dec_sig = sel_sig(i_sign, feedbak_sig[5:2]);

    always_comb begin
        case (func)
            2'b00:   jump_take = 1'b1;
            2'b01:   jump_take = dec_sig;
            2'b10:   jump_take = ~dec_sig;
            default: jump_take = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        counter_d  = counter_q;
        sign_d     = sign_q;
        cmd_data_d = cmd_data_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ACTION: begin
                        cmd_data_d = rom_data;
                        state_d    = S_CMD;
                        pc_d       = pc_q;
                    end
                    OP_JUMP: begin
                        if (jump_take) begin
                            pc_d = ADDR_W'(i_num);
                        end
                    end
                    OP_WAIT: begin
                        if (func == 2'b00 && i_num != 8'd0) begin
                            counter_d = 15'(i_num) * 15'd100;
                            state_d   = S_WAIT_T;
                            pc_d      = pc_q;
                        end else if (func == 2'b01) begin
                            sign_d  = i_sign;
                            state_d = S_WAIT_S;
                            pc_d    = pc_q;
                        end
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_WAIT_T: begin
                if (ms_tick) begin
                    counter_d = counter_q - 15'd1;
                    if (counter_q == 15'd1) begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc;
                    end
                end
            end
            S_WAIT_S: begin
                if (sel_sig(sign_q, feedbak_sig[5:2])) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything except reset, including a same-cycle handshake.
        if (abort) begin
            state_d    = S_IDLE;
            pc_d       = '0;
            counter_d  = '0;
            cmd_data_d = '0;
        end

        cmd_valid_d = (state_d == S_CMD);
        busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            counter_q   <= '0;
            sign_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            counter_q   <= counter_d;
            sign_q      <= sign_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign rom_addr  = pc_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule
